// File: rtl/alu_pkg.sv
// Shared ALU definitions: MIPS function-code encodings, control FSM states and op classification.
package alu_pkg;

  typedef enum logic [5:0] {
    SLL   = 6'b000000,
    SRL   = 6'b000010,
    SRA   = 6'b000011,
    SLLV  = 6'b000100,
    SRLV  = 6'b000110,
    SRAV  = 6'b000111,
    MULT  = 6'b011000,
    MULTU = 6'b011001,
    DIV   = 6'b011010,
    DIVU  = 6'b011011,
    ADD   = 6'b100000,
    ADDU  = 6'b100001,
    SUB   = 6'b100010,
    SUBU  = 6'b100011,
    AND   = 6'b100100,
    OR    = 6'b100101,
    XOR   = 6'b100110,
    NOR   = 6'b100111,
    SLT   = 6'b101010,
    SLTU  = 6'b101011,
    BEQ   = 6'b111000,
    BNE   = 6'b111001,
    BLEZ  = 6'b111010,
    BGTZ  = 6'b111011,
    BGEZ  = 6'b111100,
    LUI   = 6'b111101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_multicycle(input alu_op_e op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the decode/EX stage and the ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [5:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             cond;
  logic             ovf;
  logic             div0;

  modport master (
    output in_valid, op, src_a, src_b, shamt, out_ready,
    input  in_ready, out_valid, res_lo, res_hi, cond, ovf, div0
  );

  modport slave (
    input  in_valid, op, src_a, src_b, shamt, out_ready,
    output in_ready, out_valid, res_lo, res_hi, cond, ovf, div0
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative engine: shift-add multiply / restoring divide on magnitudes,
// one step per busy cycle, sign fix-up folded into the last step's output.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             div0_o
);
  localparam int CW = $clog2(WIDTH);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q, neg_lo_q, neg_hi_q, div0_q;
  logic [WIDTH-1:0] hi_q, lo_q, opb_q, a_raw_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;

  assign mag_a = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // hi_q:lo_q is the product accumulator (multiply) or remainder:dividend pair (divide)
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb_q};

  always_comb begin
    if (is_div_q) begin
      step_hi = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign prod = {step_hi, step_lo};

  always_comb begin
    done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
    div0_o = div0_q;
    if (!is_div_q) begin
      {hi_o, lo_o} = neg_lo_q ? -prod : prod;
    end else if (div0_q) begin
      lo_o = '1;
      hi_o = a_raw_q;
    end else begin
      lo_o = neg_lo_q ? -step_lo : step_lo;
      hi_o = neg_hi_q ? -step_hi : step_hi;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      busy_q <= !done_o;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      hi_q     <= '0;
      lo_q     <= mag_a;
      opb_q    <= mag_b;
      a_raw_q  <= a_i;
      is_div_q <= is_div_i;
      neg_lo_q <= is_signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      neg_hi_q <= is_signed_i && a_i[WIDTH-1];
      div0_q   <= is_div_i && (b_i == '0);
    end else if (busy_q) begin
      hi_q <= step_hi;
      lo_q <= step_lo;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked MIPS ALU: combinational single-cycle datapath into result registers,
// with MULT/DIV variants handed to the iterative engine.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  alu_multicycle_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  state_e                  state_q, state_d;
  logic                    rdy_q;
  alu_op_e                 op_w;
  logic                    accept, mc_op;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        sum_w, diff_w;
  logic [WIDTH-1:0]        sc_lo;
  logic                    sc_cond, sc_ovf;
  logic                    md_done, md_div0;
  logic [WIDTH-1:0]        md_lo, md_hi;
  logic [WIDTH-1:0]        res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic                    cond_q, cond_d, ovf_q, ovf_d, div0_q, div0_d;

  function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] d);
    return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign op_w   = alu_op_e'(bus.op);
  assign mc_op  = is_multicycle(op_w);
  assign accept = bus.in_valid && bus.in_ready;
  assign a_s    = bus.src_a;
  assign b_s    = bus.src_b;
  assign sum_w  = bus.src_a + bus.src_b;
  assign diff_w = bus.src_a - bus.src_b;

  always_comb begin
    sc_lo   = '0;
    sc_cond = 1'b0;
    sc_ovf  = 1'b0;
    case (op_w)
      ADD:   begin sc_lo = sum_w;  sc_ovf = add_ovf(bus.src_a, bus.src_b, sum_w);  end
      ADDU:  sc_lo = sum_w;
      SUB:   begin sc_lo = diff_w; sc_ovf = sub_ovf(bus.src_a, bus.src_b, diff_w); end
      SUBU:  sc_lo = diff_w;
      AND:   sc_lo = bus.src_a & bus.src_b;
      OR:    sc_lo = bus.src_a | bus.src_b;
      XOR:   sc_lo = bus.src_a ^ bus.src_b;
      NOR:   sc_lo = ~(bus.src_a | bus.src_b);
      SLT:   sc_lo = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      SLTU:  sc_lo = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
      SLL:   sc_lo = bus.src_b << bus.shamt;
      SRL:   sc_lo = bus.src_b >> bus.shamt;
      SRA:   sc_lo = b_s >>> bus.shamt;
      SLLV:  sc_lo = bus.src_b << bus.src_a[SHW-1:0];
      SRLV:  sc_lo = bus.src_b >> bus.src_a[SHW-1:0];
      SRAV:  sc_lo = b_s >>> bus.src_a[SHW-1:0];
      LUI:   sc_lo = {bus.src_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      BEQ:   sc_cond = (bus.src_a == bus.src_b);
      BNE:   sc_cond = (bus.src_a != bus.src_b);
      BLEZ:  sc_cond = bus.src_a[WIDTH-1] || (bus.src_a == '0);
      BGTZ:  sc_cond = !bus.src_a[WIDTH-1] && (bus.src_a != '0);
      BGEZ:  sc_cond = !bus.src_a[WIDTH-1];
      default: ;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk         (clk),
    .rst_b       (rst_b),
    .start_i     (accept && mc_op),
    .is_div_i    ((op_w == DIV) || (op_w == DIVU)),
    .is_signed_i ((op_w == MULT) || (op_w == DIV)),
    .a_i         (bus.src_a),
    .b_i         (bus.src_b),
    .done_o      (md_done),
    .lo_o        (md_lo),
    .hi_o        (md_hi),
    .div0_o      (md_div0)
  );

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = mc_op ? BUSY : DONE;
      BUSY:    if (md_done) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = accept ? (mc_op ? BUSY : DONE) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = rdy_q && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    bus.out_valid = (state_q == DONE);
  end

  // Result registers only load on a single-cycle accept or engine completion, so they hold under backpressure
  always_comb begin
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    cond_d   = cond_q;
    ovf_d    = ovf_q;
    div0_d   = div0_q;
    if (accept && !mc_op) begin
      res_lo_d = sc_lo;
      res_hi_d = '0;
      cond_d   = sc_cond;
      ovf_d    = sc_ovf;
      div0_d   = 1'b0;
    end else if (md_done) begin
      res_lo_d = md_lo;
      res_hi_d = md_hi;
      cond_d   = 1'b0;
      ovf_d    = 1'b0;
      div0_d   = md_div0;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      res_lo_q <= '0;
      res_hi_q <= '0;
      cond_q   <= 1'b0;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      cond_q   <= cond_d;
      ovf_q    <= ovf_d;
      div0_q   <= div0_d;
    end
  end

  assign bus.res_lo = res_lo_q;
  assign bus.res_hi = res_hi_q;
  assign bus.cond   = cond_q;
  assign bus.ovf    = ovf_q;
  assign bus.div0   = div0_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32 with hand-computed expectations.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input alu_op_e o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.shamt    = sh;
    tick();
    bus.in_valid = 1'b0;
    bus.src_a    = $urandom;
    bus.src_b    = $urandom;
    bus.shamt    = 5'(($urandom));
  endtask

  task automatic wait_engine(input string tag);
    logic ok;
    ok = 1'b1;
    for (int i = 1; i <= W; i++) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) ok = 1'b0;
      tick();
    end
    chk(tag, ok, 1'b1);
  endtask

  initial begin
    logic stable;
    rst_b         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = ADD;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.shamt     = '0;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_res_lo", bus.res_lo, 32'h0);
    chk("rst_res_hi", bus.res_hi, 32'h0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    rst_b = 1'b0;
    tick();
    chk("ready_after_release", bus.in_ready, 1'b1);

    issue(ADD, 32'h7FFFFFFF, 32'h1, 5'd0);
    chk("add_valid_cycle1", bus.out_valid, 1'b1);
    chk("add_lo", bus.res_lo, 32'h80000000);
    chk("add_ovf", bus.ovf, 1'b1);
    chk("add_hi", bus.res_hi, 32'h0);

    issue(ADDU, 32'h7FFFFFFF, 32'h1, 5'd0);
    chk("addu_lo", bus.res_lo, 32'h80000000);
    chk("addu_ovf", bus.ovf, 1'b0);

    issue(SRA, 32'h0, 32'hF0000000, 5'd4);
    chk("sra_lo", bus.res_lo, 32'hFF000000);
    issue(SLTU, 32'h1, 32'hFFFFFFFF, 5'd0);
    chk("sltu_lo", bus.res_lo, 32'h1);
    issue(SLT, 32'h1, 32'hFFFFFFFF, 5'd0);
    chk("slt_lo", bus.res_lo, 32'h0);
    issue(SRAV, 32'h4, 32'h80000000, 5'd0);
    chk("srav_lo", bus.res_lo, 32'hF8000000);
    issue(SUB, 32'h80000000, 32'h1, 5'd0);
    chk("sub_lo", bus.res_lo, 32'h7FFFFFFF);
    chk("sub_ovf", bus.ovf, 1'b1);
    issue(LUI, 32'h0, 32'hABCD1234, 5'd0);
    chk("lui_lo", bus.res_lo, 32'h12340000);
    issue(BEQ, 32'h5, 32'h5, 5'd0);
    chk("beq_cond", bus.cond, 1'b1);
    chk("beq_lo", bus.res_lo, 32'h0);
    issue(BLEZ, 32'h0, 32'h9, 5'd0);
    chk("blez_zero", bus.cond, 1'b1);
    issue(BGTZ, 32'h0, 32'h9, 5'd0);
    chk("bgtz_zero", bus.cond, 1'b0);
    issue(alu_op_e'(6'b001111), 32'h12345678, 32'h9ABCDEF0, 5'd3);
    chk("undef_valid", bus.out_valid, 1'b1);
    chk("undef_lo", bus.res_lo, 32'h0);

    issue(MULT, 32'hFFFFFFFD, 32'h5, 5'd0);
    wait_engine("mult_busy");
    chk("mult_valid_cycle33", bus.out_valid, 1'b1);
    chk("mult_hi", bus.res_hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.res_lo, 32'hFFFFFFF1);

    issue(MULTU, 32'hFFFFFFFF, 32'h2, 5'd0);
    wait_engine("multu_busy");
    chk("multu_hilo", {bus.res_hi, bus.res_lo}, 64'h00000001_FFFFFFFE);

    issue(DIV, 32'hFFFFFFF9, 32'h2, 5'd0);
    wait_engine("div_busy");
    chk("div_lo", bus.res_lo, 32'hFFFFFFFD);
    chk("div_hi", bus.res_hi, 32'hFFFFFFFF);

    issue(DIVU, 32'h7, 32'h0, 5'd0);
    wait_engine("divu0_busy");
    chk("divu0_flag", bus.div0, 1'b1);
    chk("divu0_lo", bus.res_lo, 32'hFFFFFFFF);
    chk("divu0_hi", bus.res_hi, 32'h7);

    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0);
    wait_engine("divmin_busy");
    chk("divmin_lo", bus.res_lo, 32'h80000000);
    chk("divmin_hi", bus.res_hi, 32'h0);
    chk("divmin_div0", bus.div0, 1'b0);

    tick();
    bus.out_ready = 1'b0;
    issue(ADD, 32'h3, 32'h4, 5'd0);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid !== 1'b1 || bus.res_lo !== 32'h7 || bus.in_ready !== 1'b0) stable = 1'b0;
      tick();
    end
    chk("hold_stable", stable, 1'b1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = SUBU;
    bus.src_a     = 32'hA;
    bus.src_b     = 32'h4;
    #1;
    chk("b2b_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_valid", bus.out_valid, 1'b1);
    chk("b2b_lo", bus.res_lo, 32'h6);

    issue(DIV, 32'd100, 32'd7, 5'd0);
    for (int i = 0; i < 9; i++) tick();
    rst_b = 1'b1;
    #1;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_res_lo", bus.res_lo, 32'h0);
    chk("abort_in_ready", bus.in_ready, 1'b0);
    tick();
    rst_b = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) stable = 1'b0;
    end
    chk("abort_no_result", stable, 1'b1);
    issue(ADD, 32'h2, 32'h3, 5'd0);
    chk("post_abort_valid", bus.out_valid, 1'b1);
    chk("post_abort_lo", bus.res_lo, 32'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
